// File: rtl/pong_game_ctrl.sv
// Game-sequencing FSM for VGA pong: menu, max-score setup, serve, play, point hold, game end.
// Owns both scores, the winning score and serve side; every output is registered.
module pong_game_ctrl #(
    parameter int unsigned SCORE_W           = 5,
    parameter int unsigned MAX_SCORE_DEFAULT = 5,
    parameter int unsigned MAX_SCORE_LIMIT   = 15,
    parameter int unsigned POINT_HOLD_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               launch,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               left_hit,
    input  logic               right_hit,
    output logic [2:0]         state,
    output logic               play_en,
    output logic               serve_load,
    output logic               start_player,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [SCORE_W-1:0] max_score,
    output logic               game_over,
    output logic               winner
);

    localparam int unsigned HoldW = (POINT_HOLD_FRAMES > 1) ? $clog2(POINT_HOLD_FRAMES) : 1;

    typedef enum logic [2:0] {
        StMenu     = 3'd0,
        StSet      = 3'd1,
        StStart    = 3'd2,
        StPlay     = 3'd3,
        StEndPoint = 3'd4,
        StEndGame  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic [SCORE_W-1:0] max_score_q, max_score_d;
    logic               start_player_q, start_player_d;
    logic               winner_q, winner_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic               launch_prev_q, up_prev_q, down_prev_q;
    logic               play_en_q, play_en_d;
    logic               serve_load_q, serve_load_d;
    logic               game_over_q, game_over_d;

    logic launch_rise, up_rise, down_rise;
    logic hold_last, p1_won, p2_won;

    assign launch_rise = launch & ~launch_prev_q;
    assign up_rise     = btn_up & ~up_prev_q;
    assign down_rise   = btn_down & ~down_prev_q;
    assign hold_last   = (hold_cnt_q == HoldW'(POINT_HOLD_FRAMES - 1));
    assign p1_won      = (score_p1_q >= max_score_q);
    assign p2_won      = (score_p2_q >= max_score_q);

    // Edge history resets high so a button held through reset release is not a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StMenu;
            score_p1_q     <= '0;
            score_p2_q     <= '0;
            max_score_q    <= SCORE_W'(MAX_SCORE_DEFAULT);
            start_player_q <= 1'b0;
            winner_q       <= 1'b0;
            hold_cnt_q     <= '0;
            launch_prev_q  <= 1'b1;
            up_prev_q      <= 1'b1;
            down_prev_q    <= 1'b1;
            play_en_q      <= 1'b0;
            serve_load_q   <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            score_p1_q     <= score_p1_d;
            score_p2_q     <= score_p2_d;
            max_score_q    <= max_score_d;
            start_player_q <= start_player_d;
            winner_q       <= winner_d;
            hold_cnt_q     <= hold_cnt_d;
            launch_prev_q  <= launch;
            up_prev_q      <= btn_up;
            down_prev_q    <= btn_down;
            play_en_q      <= play_en_d;
            serve_load_q   <= serve_load_d;
            game_over_q    <= game_over_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        score_p1_d     = score_p1_q;
        score_p2_d     = score_p2_q;
        max_score_d    = max_score_q;
        start_player_d = start_player_q;
        winner_d       = winner_q;
        hold_cnt_d     = hold_cnt_q;
        unique case (state_q)
            StMenu: begin
                if (launch_rise) state_d = StSet;
            end
            StSet: begin
                if (up_rise && !down_rise && (max_score_q < SCORE_W'(MAX_SCORE_LIMIT))) begin
                    max_score_d = max_score_q + SCORE_W'(1);
                end else if (down_rise && !up_rise && (max_score_q > SCORE_W'(1))) begin
                    max_score_d = max_score_q - SCORE_W'(1);
                end
                if (launch_rise) begin
                    state_d        = StStart;
                    score_p1_d     = '0;
                    score_p2_d     = '0;
                    start_player_d = 1'b0;
                end
            end
            StStart: begin
                if (launch_rise) state_d = StPlay;
            end
            StPlay: begin
                // Simultaneous hits are ambiguous and dropped.
                if (right_hit && !left_hit) begin
                    score_p1_d     = score_p1_q + SCORE_W'(1);
                    start_player_d = 1'b1;
                    hold_cnt_d     = '0;
                    state_d        = StEndPoint;
                end else if (left_hit && !right_hit) begin
                    score_p2_d     = score_p2_q + SCORE_W'(1);
                    start_player_d = 1'b0;
                    hold_cnt_d     = '0;
                    state_d        = StEndPoint;
                end
            end
            StEndPoint: begin
                if (frame_tick) begin
                    if (hold_last) begin
                        if (p1_won) begin
                            state_d  = StEndGame;
                            winner_d = 1'b0;
                        end else if (p2_won) begin
                            state_d  = StEndGame;
                            winner_d = 1'b1;
                        end else begin
                            state_d = StStart;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldW'(1);
                    end
                end
            end
            StEndGame: begin
                if (launch_rise) begin
                    state_d    = StMenu;
                    score_p1_d = '0;
                    score_p2_d = '0;
                end
            end
            default: state_d = StMenu;
        endcase
    end

    always_comb begin
        play_en_d    = (state_d == StPlay);
        serve_load_d = (state_d == StStart);
        game_over_d  = (state_d == StEndGame);
    end

    assign state        = state_q;
    assign play_en      = play_en_q;
    assign serve_load   = serve_load_q;
    assign game_over    = game_over_q;
    assign start_player = start_player_q;
    assign winner       = winner_q;
    assign score_p1     = score_p1_q;
    assign score_p2     = score_p2_q;
    assign max_score    = max_score_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Vector-table bench for pong_game_ctrl: each step's expected outputs go through a
// scoreboard queue and are compared one cycle later; async reset is checked by hand.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick, launch, btn_up, btn_down, left_hit, right_hit;
    logic [2:0] state;
    logic       play_en, serve_load, start_player, game_over, winner;
    logic [4:0] score_p1, score_p2, max_score;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .launch       (launch),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .left_hit     (left_hit),
        .right_hit    (right_hit),
        .state        (state),
        .play_en      (play_en),
        .serve_load   (serve_load),
        .start_player (start_player),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .max_score    (max_score),
        .game_over    (game_over),
        .winner       (winner)
    );

    typedef struct {
        string      name;
        logic       l, u, d, lh, rh, ft;
        logic [2:0] st;
        logic [4:0] p1, p2, mx;
        logic       sp, win;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [2:0] e_st;
    logic [4:0] e_p1, e_p2, e_mx;
    logic       e_sp, e_win;

    task automatic add(input string n, input logic l, u, d, lh, rh, ft);
        vec_t v;
        v.name = n; v.l = l; v.u = u; v.d = d; v.lh = lh; v.rh = rh; v.ft = ft;
        v.st = e_st; v.p1 = e_p1; v.p2 = e_p2; v.mx = e_mx; v.sp = e_sp; v.win = e_win;
        tbl.push_back(v);
    endtask

    task automatic add_ticks(input string n, input int cnt);
        for (int i = 0; i < cnt; i++) add(n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // {state, play_en, serve_load, game_over, winner, start_player, p1, p2, max}
    function automatic logic [22:0] exp_word(input vec_t v);
        return {v.st, v.st == 3'd3, v.st == 3'd2, v.st == 3'd5, v.win, v.sp, v.p1, v.p2, v.mx};
    endfunction

    task automatic check_front();
        vec_t       e;
        logic [22:0] act, req;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: actual=empty required=entry");
            return;
        end
        e   = sb.pop_front();
        act = {state, play_en, serve_load, game_over, winner, start_player,
               score_p1, score_p2, max_score};
        req = exp_word(e);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual st=%0d pe=%b sl=%b go=%b w=%b sp=%b p1=%0d p2=%0d mx=%0d required st=%0d pe=%b sl=%b go=%b w=%b sp=%b p1=%0d p2=%0d mx=%0d",
                     e.name, act[22:20], act[19], act[18], act[17], act[16], act[15],
                     act[14:10], act[9:5], act[4:0], req[22:20], req[19], req[18], req[17],
                     req[16], req[15], req[14:10], req[9:5], req[4:0]);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        launch = v.l; btn_up = v.u; btn_down = v.d;
        left_hit = v.lh; right_hit = v.rh; frame_tick = v.ft;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_front();
    endtask

    task automatic push_reset_exp(input string n);
        vec_t v;
        v.name = n; v.l = 0; v.u = 0; v.d = 0; v.lh = 0; v.rh = 0; v.ft = 0;
        v.st = 3'd0; v.p1 = 5'd0; v.p2 = 5'd0; v.mx = 5'd5; v.sp = 1'b0; v.win = 1'b0;
        sb.push_back(v);
    endtask

    initial begin
        reset_n = 1'b0; launch = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        left_hit = 1'b0; right_hit = 1'b0; frame_tick = 1'b0;

        e_st = 3'd0; e_p1 = 5'd0; e_p2 = 5'd0; e_mx = 5'd5; e_sp = 1'b0; e_win = 1'b0;
        add("hold_launch_after_reset", 1, 0, 0, 0, 0, 0);
        add("release_launch", 0, 0, 0, 0, 0, 0);
        e_st = 3'd1;
        add("menu_to_set", 1, 0, 0, 0, 0, 0);
        add("held_launch_no_chain", 1, 0, 0, 0, 0, 0);
        add("set_release", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            e_mx = e_mx + 5'd1;
            add("up_x3", 0, 1, 0, 0, 0, 0);
            add("up_x3_rel", 0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 20; i++) begin
            if (e_mx < 5'd15) e_mx = e_mx + 5'd1;
            add("up_sat", 0, 1, 0, 0, 0, 0);
            add("up_sat_rel", 0, 0, 0, 0, 0, 0);
        end
        add("up_down_together", 0, 1, 1, 0, 0, 0);
        add("up_down_rel", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (e_mx > 5'd1) e_mx = e_mx - 5'd1;
            add("down_sat", 0, 0, 1, 0, 0, 0);
            add("down_sat_rel", 0, 0, 0, 0, 0, 0);
        end
        e_mx = 5'd2;
        add("up_to_2", 0, 1, 0, 0, 0, 0);
        add("up_to_2_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd2;
        add("set_to_start", 1, 0, 0, 0, 0, 0);
        add("start_rel", 0, 0, 0, 0, 0, 0);
        add("hit_in_start", 0, 0, 0, 0, 1, 0);
        add("hit_in_start_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd3;
        add("start_to_play", 1, 0, 0, 0, 0, 0);
        add("play_rel", 0, 0, 0, 0, 0, 0);
        add("both_hits", 0, 0, 0, 1, 1, 0);
        add("both_hits_rel", 0, 0, 0, 0, 0, 0);
        add("launch_in_play", 1, 0, 0, 0, 0, 0);
        add("launch_in_play_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd4; e_p1 = 5'd1; e_sp = 1'b1;
        add("right_hit_point", 0, 0, 0, 0, 1, 0);
        add("right_hit_rel", 0, 0, 0, 0, 0, 0);
        add("hit_in_end_point", 0, 0, 0, 1, 0, 0);
        add("hit_in_end_point_rel", 0, 0, 0, 0, 0, 0);
        add_ticks("hold_p1", 59);
        e_st = 3'd2;
        add_ticks("hold_p1_done", 1);
        e_st = 3'd3;
        add("serve2", 1, 0, 0, 0, 0, 0);
        add("serve2_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd4; e_p2 = 5'd1; e_sp = 1'b0;
        add("left_hit_point", 0, 0, 0, 1, 0, 0);
        add("left_hit_rel", 0, 0, 0, 0, 0, 0);
        add_ticks("hold_p2", 59);
        e_st = 3'd2;
        add_ticks("hold_p2_done", 1);
        e_st = 3'd3;
        add("serve3", 1, 0, 0, 0, 0, 0);
        add("serve3_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd4; e_p1 = 5'd2; e_sp = 1'b1;
        add("right_hit_win", 0, 0, 0, 0, 1, 0);
        add("right_hit_win_rel", 0, 0, 0, 0, 0, 0);
        add_ticks("hold_win", 59);
        e_st = 3'd5; e_win = 1'b0;
        add_ticks("game_over_p1", 1);
        add("hit_in_end_game", 0, 0, 0, 0, 1, 0);
        add("hit_in_end_game_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd0; e_p1 = 5'd0; e_p2 = 5'd0;
        add("end_game_to_menu", 1, 0, 0, 0, 0, 0);
        add("menu_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd1;
        add("g2_set", 1, 0, 0, 0, 0, 0);
        add("g2_set_rel", 0, 0, 0, 0, 0, 0);
        e_mx = 5'd1;
        add("g2_down_to_1", 0, 0, 1, 0, 0, 0);
        add("g2_down_rel", 0, 0, 0, 0, 0, 0);
        add("g2_down_floor", 0, 0, 1, 0, 0, 0);
        add("g2_down_floor_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd2; e_sp = 1'b0;
        add("g2_start", 1, 0, 0, 0, 0, 0);
        add("g2_start_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd3;
        add("g2_play", 1, 0, 0, 0, 0, 0);
        add("g2_play_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd4; e_p2 = 5'd1;
        add("g2_left_hit", 0, 0, 0, 1, 0, 0);
        add("g2_left_hit_rel", 0, 0, 0, 0, 0, 0);
        add_ticks("g2_hold", 59);
        e_st = 3'd5; e_win = 1'b1;
        add_ticks("game_over_p2", 1);
        e_st = 3'd0; e_p2 = 5'd0;
        add("g2_to_menu", 1, 0, 0, 0, 0, 0);
        add("g2_menu_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd1;
        add("g3_set", 1, 0, 0, 0, 0, 0);
        add("g3_set_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd2;
        add("g3_start", 1, 0, 0, 0, 0, 0);
        add("g3_start_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd3;
        add("g3_play", 1, 0, 0, 0, 0, 0);
        add("g3_play_rel", 0, 0, 0, 0, 0, 0);
        e_st = 3'd4; e_p2 = 5'd1; e_sp = 1'b0;
        add("g3_left_hit", 0, 0, 0, 1, 0, 0);
        add("g3_left_hit_rel", 0, 0, 0, 0, 0, 0);
        add_ticks("g3_hold30", 30);

        // Reset state while reset_n is low, launch held.
        repeat (3) @(negedge clk);
        push_reset_exp("reset_state");
        check_front();
        reset_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Async assert mid-hold: outputs must clear before any further clk edge.
        @(negedge clk);
        launch = 1'b0; frame_tick = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        push_reset_exp("async_reset_mid_hold");
        check_front();
        @(negedge clk);
        reset_n = 1'b1;
        push_reset_exp("after_reset_release");
        @(posedge clk);
        #1;
        check_front();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
